// File: rtl/dot_pkg.sv
// Shared sideband type and width helpers for the dot-product pipeline.
package dot_pkg;

    // Valid/last sideband that travels alongside the data of every stage.
    typedef struct packed {
        logic valid;
        logic last;
    } sband_t;

    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    // Width of an adder-tree node at a given level for w-bit elements.
    function automatic int tree_w(input int w, input int level);
        return 2 * w + level;
    endfunction

endpackage

// File: rtl/adder_tree.sv
// Pipelined binary adder tree: one registered level per log2(N) step,
// each level one bit wider than the one below, sideband carried alongside.
module adder_tree
    import dot_pkg::*;
#(
    parameter int N      = 32,
    parameter int IN_W   = 16,
    parameter int SIGNED = 0,
    localparam int LOG2N = log2n(N),
    localparam int OUT_W = IN_W + LOG2N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*IN_W-1:0] in_data,
    input  sband_t            in_sb,
    output logic [OUT_W-1:0]  out_data,
    output sband_t            out_sb
);

    genvar l, i;
    for (l = 0; l <= LOG2N; l++) begin : g_lvl
        localparam int LW  = IN_W + l;
        localparam int CNT = N >> l;

        logic [CNT*LW-1:0] data;
        sband_t            sb;

        if (l == 0) begin : g_src
            assign data = in_data;
            assign sb   = in_sb;
        end else begin : g_add
            logic [CNT*LW-1:0] sum;

            for (i = 0; i < CNT; i++) begin : g_node
                logic [LW-2:0] a;
                logic [LW-2:0] b;
                assign a = g_lvl[l-1].data[(2*i)*(LW-1) +: (LW-1)];
                assign b = g_lvl[l-1].data[(2*i+1)*(LW-1) +: (LW-1)];
                // Extend by one bit before adding so the pair sum cannot wrap.
                assign sum[i*LW +: LW] = ((SIGNED != 0) ? {a[LW-2], a} : {1'b0, a})
                                       + ((SIGNED != 0) ? {b[LW-2], b} : {1'b0, b});
            end

            // Tree level l boundary
            always_ff @(posedge clk) begin
                data <= sum;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sb <= '0;
                end else begin
                    sb <= g_lvl[l-1].sb;
                end
            end
        end
    end

    assign out_data = g_lvl[LOG2N].data;
    assign out_sb   = g_lvl[LOG2N].sb;

endmodule

// File: rtl/dot_product_pipe.sv
// Pipelined dot-product engine: capture, N parallel multiplies, adder tree,
// chunk accumulator and registered result with a one-cycle valid pulse.
module dot_product_pipe
    import dot_pkg::*;
#(
    parameter int N      = 32,
    parameter int W      = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   row,
    input  logic [N*W-1:0]   col,
    input  logic             axiiv,
    input  logic             axiil,
    output logic             axiov,
    output logic [ACC_W-1:0] axiod,
    output logic             ovf
);

    localparam int LOG2N  = log2n(N);
    localparam int PROD_W = tree_w(W, 0);
    localparam int TREE_W = tree_w(W, LOG2N);

    function automatic logic [PROD_W-1:0] mul_elem(input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic signed [PROD_W-1:0] sx;
        logic signed [PROD_W-1:0] sy;
        logic        [PROD_W-1:0] ux;
        logic        [PROD_W-1:0] uy;
        sx = PROD_W'($signed(a));
        sy = PROD_W'($signed(b));
        ux = PROD_W'(a);
        uy = PROD_W'(b);
        if (SIGNED != 0) return sx * sy;
        return ux * uy;
    endfunction

    function automatic logic [ACC_W-1:0] ext_acc(input logic [TREE_W-1:0] t);
        if (SIGNED != 0) return ACC_W'($signed(t));
        return ACC_W'(t);
    endfunction

    // Unsigned carry-out, or two's-complement overflow when both operands
    // share a sign that the wrapped sum does not.
    function automatic logic acc_ovf(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] b,
                                     input logic [ACC_W-1:0] s,
                                     input logic             carry);
        if (SIGNED != 0) return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        return carry;
    endfunction

    // S0: input capture
    logic [N*W-1:0] row_p0;
    logic [N*W-1:0] col_p0;
    sband_t         sb_p0;

    always_ff @(posedge clk) begin
        row_p0 <= row;
        col_p0 <= col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_p0 <= '0;
        end else begin
            sb_p0.valid <= axiiv;
            sb_p0.last  <= axiiv & axiil;
        end
    end

    // S1: element-wise multiply
    logic [N*PROD_W-1:0] prod_p1;
    sband_t              sb_p1;

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            prod_p1[k*PROD_W +: PROD_W] <= mul_elem(row_p0[k*W +: W], col_p0[k*W +: W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_p1 <= '0;
        end else begin
            sb_p1 <= sb_p0;
        end
    end

    // S2..S(1+LOG2N): adder tree
    logic [TREE_W-1:0] tree_sum;
    sband_t            tree_sb;

    adder_tree #(
        .N      (N),
        .IN_W   (PROD_W),
        .SIGNED (SIGNED)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .in_data  (prod_p1),
        .in_sb    (sb_p1),
        .out_data (tree_sum),
        .out_sb   (tree_sb)
    );

    // SA: accumulate
    logic [ACC_W-1:0] acc;
    logic             first;
    logic             ovf_acc;
    logic             done_pa;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             ovf_run;

    always_comb begin
        addend       = ext_acc(tree_sum);
        base         = first ? '0 : acc;
        {carry, sum} = {1'b0, base} + {1'b0, addend};
        ovf_run      = (first ? 1'b0 : ovf_acc) | acc_ovf(base, addend, sum, carry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            first   <= 1'b1;
            ovf_acc <= 1'b0;
            done_pa <= 1'b0;
        end else begin
            done_pa <= tree_sb.valid & tree_sb.last;
            if (tree_sb.valid) begin
                acc     <= sum;
                ovf_acc <= ovf_run;
                first   <= tree_sb.last;
            end
        end
    end

    // Output register: result and flag held until the next pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            axiov <= 1'b0;
            axiod <= '0;
            ovf   <= 1'b0;
        end else begin
            axiov <= done_pa;
            if (done_pa) begin
                axiod <= acc;
                ovf   <= ovf_acc;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_pipe.sv
// Directed bench for dot_product_pipe: unsigned and signed instances share
// the same stimulus; a scoreboard checks value, flag, latency and hold.
module tb_dot_product_pipe;

    localparam int N     = 32;
    localparam int W     = 8;
    localparam int ACC_W = 24;
    localparam int L     = 8;
    localparam int NV    = 11;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic [N*W-1:0]   row   = '0;
    logic [N*W-1:0]   col   = '0;
    logic             axiiv = 1'b0;
    logic             axiil = 1'b0;
    logic             axiov_u, axiov_s, ovf_u, ovf_s;
    logic [ACC_W-1:0] axiod_u, axiod_s;

    dot_product_pipe #(.N(N), .W(W), .ACC_W(ACC_W), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .axiiv(axiiv), .axiil(axiil),
        .axiov(axiov_u), .axiod(axiod_u), .ovf(ovf_u)
    );

    dot_product_pipe #(.N(N), .W(W), .ACC_W(ACC_W), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .axiiv(axiiv), .axiil(axiil),
        .axiov(axiov_s), .axiod(axiod_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] d_u;
        logic             o_u;
        logic [ACC_W-1:0] d_s;
        logic             o_s;
        int               due;
    } exp_t;

    typedef struct {
        int               nsl;
        int               gap;
        logic [W-1:0]     rv;
        logic [W-1:0]     cv;
        bit               rr;
        bit               cr;
        logic [ACC_W-1:0] du;
        logic             ou;
        logic [ACC_W-1:0] ds;
        logic             os;
    } vec_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    vec_t             tbl[NV];
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    logic             rst_q = 1'b0;
    logic [ACC_W-1:0] hold_u = '0;
    logic [ACC_W-1:0] hold_s = '0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            check1("reset axiov_u", axiov_u, 1'b0);
            check1("reset axiov_s", axiov_s, 1'b0);
            checkw("reset axiod_u", axiod_u, '0);
            checkw("reset axiod_s", axiod_s, '0);
            check1("reset ovf_u", ovf_u, 1'b0);
            check1("reset ovf_s", ovf_s, 1'b0);
            hold_u = '0;
            hold_s = '0;
        end else if (axiov_u || axiov_s) begin
            if (exp_q.size() == 0) begin
                check1("spurious axiov", axiov_u | axiov_s, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check1("axiov_u", axiov_u, 1'b1);
                check1("axiov_s", axiov_s, 1'b1);
                checkw("axiod_u", axiod_u, mon_e.d_u);
                check1("ovf_u", ovf_u, mon_e.o_u);
                checkw("axiod_s", axiod_s, mon_e.d_s);
                check1("ovf_s", ovf_s, mon_e.o_s);
                checki("latency cycle", cyc, mon_e.due);
            end
            hold_u = axiod_u;
            hold_s = axiod_s;
        end else begin
            checkw("hold axiod_u", axiod_u, hold_u);
            checkw("hold axiod_s", axiod_s, hold_s);
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                checki("missing axiov at cycle", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(i);
        return r;
    endfunction

    task automatic drive(input logic [N*W-1:0] r, input logic [N*W-1:0] c,
                         input logic v, input logic l);
        row   = r;
        col   = c;
        axiiv = v;
        axiil = l;
        @(posedge clk);
        #1;
        axiiv = 1'b0;
        axiil = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(rep(8'h00), rep(8'h00), 1'b0, 1'b0);
    endtask

    // Called just after the capture edge of a last slice.
    task automatic expect_result(input logic [ACC_W-1:0] du, input logic ou,
                                 input logic [ACC_W-1:0] ds, input logic os);
        exp_t e;
        e.d_u = du;
        e.o_u = ou;
        e.d_s = ds;
        e.o_s = os;
        e.due = cyc + L;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [N*W-1:0] r;
        logic [N*W-1:0] c;

        //          nsl gap rv     cv     rr cr  u result       ou  s result      os
        tbl[0]  = '{1,  0, 8'h01, 8'h01, 0, 0, 24'd32,       0, 24'd32,       0};
        tbl[1]  = '{1,  0, 8'hFF, 8'hFF, 0, 0, 24'd2080800,  0, 24'd32,       0};
        tbl[2]  = '{1,  0, 8'hFF, 8'h01, 0, 0, 24'd8160,     0, 24'hFFFFE0,   0};
        tbl[3]  = '{2,  0, 8'hFF, 8'h01, 0, 0, 24'd16320,    0, 24'hFFFFC0,   0};
        tbl[4]  = '{2,  2, 8'hFF, 8'h01, 0, 0, 24'd16320,    0, 24'hFFFFC0,   0};
        tbl[5]  = '{9,  0, 8'hFF, 8'hFF, 0, 0, 24'd1949984,  1, 24'd288,      0};
        tbl[6]  = '{1,  0, 8'h01, 8'h01, 0, 0, 24'd32,       0, 24'd32,       0};
        tbl[7]  = '{16, 0, 8'h80, 8'h80, 0, 0, 24'h800000,   0, 24'h800000,   1};
        tbl[8]  = '{1,  0, 8'h00, 8'h03, 1, 0, 24'd1488,     0, 24'd1488,     0};
        tbl[9]  = '{1,  0, 8'h00, 8'h00, 1, 1, 24'd10416,    0, 24'd10416,    0};
        tbl[10] = '{1,  1, 8'h80, 8'h7F, 0, 0, 24'd520192,   0, 24'hF81000,   0};

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Table vectors run back to back; bubbles carry junk data and axiil=1.
        for (int v = 0; v < NV; v++) begin
            r = tbl[v].rr ? ramp() : rep(tbl[v].rv);
            c = tbl[v].cr ? ramp() : rep(tbl[v].cv);
            for (int s = 0; s < tbl[v].nsl; s++) begin
                drive(r, c, 1'b1, s == tbl[v].nsl - 1);
                if (s != tbl[v].nsl - 1) begin
                    for (int g = 0; g < tbl[v].gap; g++) drive(rep(8'hA5), rep(8'h5A), 1'b0, 1'b1);
                end
            end
            expect_result(tbl[v].du, tbl[v].ou, tbl[v].ds, tbl[v].os);
        end
        idle(L + 2);

        // Three-slice vector of 1s, 2s, 3s then an immediate single slice of 1s.
        drive(rep(8'd1), rep(8'd1), 1'b1, 1'b0);
        drive(rep(8'd2), rep(8'd2), 1'b1, 1'b0);
        drive(rep(8'd3), rep(8'd3), 1'b1, 1'b1);
        expect_result(24'd448, 1'b0, 24'd448, 1'b0);
        drive(rep(8'd1), rep(8'd1), 1'b1, 1'b1);
        expect_result(24'd32, 1'b0, 24'd32, 1'b0);
        idle(L + 2);

        // Reset during the 2nd slice; the last slice also arrives under reset.
        drive(rep(8'd5), rep(8'd5), 1'b1, 1'b0);
        rst = 1'b1;
        drive(rep(8'd5), rep(8'd5), 1'b1, 1'b0);
        drive(rep(8'd5), rep(8'd5), 1'b1, 1'b1);
        rst = 1'b0;
        idle(L + 4);
        drive(rep(8'd1), rep(8'd1), 1'b1, 1'b1);
        expect_result(24'd32, 1'b0, 24'd32, 1'b0);
        idle(L + 2);

        // Partial sum already in the accumulator must be discarded by reset.
        drive(rep(8'd2), rep(8'd2), 1'b1, 1'b0);
        drive(rep(8'd2), rep(8'd2), 1'b1, 1'b0);
        idle(L + 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        drive(rep(8'd1), rep(8'd1), 1'b1, 1'b1);
        expect_result(24'd32, 1'b0, 24'd32, 1'b0);
        idle(L + 4);

        checki("pending results", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
